// File: rtl/test_opt_reg_arb_if.sv
// Handshake bundle between NumReq requesters, the shared output register and its consumer.
// Latency: none, this is wiring only.
// Backpressure: out_ready from the consumer gates the req_ready grants driven back to the requesters.
interface test_opt_reg_arb_if #(
    parameter int DataWidth = 16,
    parameter int NumReq    = 4
);
    localparam int IdWidth = (NumReq > 2) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]           req_valid;
    logic [NumReq*DataWidth-1:0] req_data;
    logic [NumReq-1:0]           req_ready;
    logic                        out_valid;
    logic [DataWidth-1:0]        out_data;
    logic [IdWidth-1:0]          out_id;
    logic                        out_ready;

    // Drives requests and consumes the register: the requesters and consumer together.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    // The arbitrated register itself.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/test_opt_reg_arb.sv
// Round-robin arbiter feeding a single shared output register, tagged with the winner's index.
// Latency: 1 cycle from a grant to out_valid; sustains one word per cycle.
// Backpressure: grants only when the register is empty or draining (out_ready); a stalled full register holds.
module test_opt_reg_arb #(
    parameter int DataWidth = 16,
    parameter int NumReq    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    test_opt_reg_arb_if.slave bus
);
    localparam int IdWidth  = (NumReq > 2) ? $clog2(NumReq) : 1;
    localparam int SumWidth = IdWidth + 1;

    // The register occupancy is the whole state; out_valid is simply "FULL".
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                r_state;
    logic [DataWidth-1:0]  r_data;
    logic [IdWidth-1:0]    r_id;
    logic [IdWidth-1:0]    r_rr_ptr;

    logic                  w_load;
    logic                  w_found;
    logic                  w_xfer;
    logic [IdWidth-1:0]    w_gidx;
    logic [IdWidth-1:0]    w_next_ptr;
    logic [NumReq-1:0]     w_grant;
    logic [DataWidth-1:0]  w_gdata;

    // The register can accept a word when empty or when its current word leaves this cycle.
    assign w_load = (r_state == EMPTY) || bus.out_ready;

    // Scan upward from the round-robin pointer, wrapping, and keep the first valid requester.
    always_comb begin
        logic [SumWidth-1:0] v_pos;
        w_found = 1'b0;
        w_gidx  = '0;
        v_pos   = '0;
        for (int k = 0; k < NumReq; k++) begin
            v_pos = {1'b0, r_rr_ptr} + SumWidth'(k);
            if (v_pos >= SumWidth'(NumReq)) begin
                v_pos = v_pos - SumWidth'(NumReq);
            end
            if (!w_found && bus.req_valid[v_pos[IdWidth-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = v_pos[IdWidth-1:0];
            end
        end
    end

    // rst_n is folded in so no grant can leak out while the register is held in reset.
    assign w_xfer  = w_load && w_found && rst_n;
    assign w_grant = w_xfer ? (NumReq'(1) << w_gidx) : '0;

    // Select the winning requester's word.
    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_gidx == IdWidth'(i)) begin
                w_gdata = bus.req_data[i*DataWidth +: DataWidth];
            end
        end
    end

    // The winner moves to the back of the rotation.
    assign w_next_ptr = (w_gidx == IdWidth'(NumReq - 1)) ? '0 : w_gidx + 1'b1;

    // Register state machine: fill on a grant, drain to EMPTY when consumed with nothing to replace it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_data   <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_state  <= FULL;
            r_data   <= w_gdata;
            r_id     <= w_gidx;
            r_rr_ptr <= w_next_ptr;
        end else if (bus.out_ready) begin
            // Data and id keep their last values once the register empties.
            r_state  <= EMPTY;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_data;
    assign bus.out_id    = r_id;
endmodule

// File: tb/tb_test_opt_reg_arb.sv
module tb_test_opt_reg_arb;
    localparam int DW = 16;
    localparam int NR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    test_opt_reg_arb_if #(.DataWidth(DW), .NumReq(NR)) bus ();
    test_opt_reg_arb #(.DataWidth(DW), .NumReq(NR)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Narrowest legal build: one data bit, two requesters.
    test_opt_reg_arb_if #(.DataWidth(1), .NumReq(2)) sbus ();
    test_opt_reg_arb #(.DataWidth(1), .NumReq(2)) sdut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sbus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] dat;
    } word_t;

    // Reference model: register contents, rotation pointer, in-flight words, per-requester wait.
    bit            m_vld;
    logic [DW-1:0] m_dat;
    int            m_id;
    int            m_ptr;
    word_t         sb[$];
    int            wait_cnt[NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 0;
        m_dat = '0;
        m_id  = 0;
        m_ptr = 0;
        sb.delete();
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endtask

    // First offering requester at or after ptr, going round the ring; -1 if none.
    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // One clock: check outputs and grant against the model mid-cycle, advance the model,
    // then return just after the next rising edge, ready for new inputs.
    task automatic cyc();
        int            g;
        bit            load;
        logic [NR-1:0] eg;
        word_t         w;
        @(negedge clk);
        chk("out_valid", bus.out_valid, m_vld);
        chk("out_data", bus.out_data, m_dat);
        chk("out_id", bus.out_id, m_id);
        load = !m_vld || bus.out_ready;
        g    = load ? pick(bus.req_valid, m_ptr) : -1;
        eg   = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", bus.req_ready, eg);
        if (m_vld && bus.out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                chk("sb_id", bus.out_id, w.id);
                chk("sb_dat", bus.out_data, w.dat);
            end
            m_vld = 0;
        end
        if (g >= 0) begin
            chk("fair_wait", wait_cnt[g] < NR, 1);
            for (int i = 0; i < NR; i++) begin
                if (i == g || !bus.req_valid[i]) wait_cnt[i] = 0;
                else wait_cnt[i]++;
            end
            w.id  = g;
            w.dat = bus.req_data[g*DW +: DW];
            sb.push_back(w);
            m_vld = 1;
            m_dat = w.dat;
            m_id  = g;
            m_ptr = (g + 1) % NR;
        end else begin
            for (int i = 0; i < NR; i++) if (!bus.req_valid[i]) wait_cnt[i] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with every requester offering so grant gating is exercised.
        model_reset();
        bus.req_valid  = '1;
        bus.req_data   = '0;
        bus.out_ready  = 1'b1;
        sbus.req_valid = '1;
        sbus.req_data  = '0;
        sbus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_small_req_ready", sbus.req_ready, 0);
        bus.req_valid  = '0;
        sbus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All requesters busy, consumer always ready: strict rotation 0,1,2,3,0,1,2,3.
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = DW'(16'h1000 + i);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("rot_valid", bus.out_valid, 1);
            chk("rot_id", bus.out_id, c % NR);
        end
        bus.req_valid = '0;
        cyc();

        // Lone requester 2 against a stalled consumer.
        bus.req_valid = 4'b0100;
        bus.req_data  = '0;
        bus.req_data[2*DW +: DW] = 16'h00AA;
        bus.out_ready = 1'b0;
        #1;
        chk("stall_first_grant", bus.req_ready, 4'b0100);
        cyc();
        bus.req_data[2*DW +: DW] = 16'h00BB;
        for (int c = 0; c < 5; c++) begin
            chk("stall_no_grant", bus.req_ready, 0);
            chk("stall_hold_data", bus.out_data, 16'h00AA);
            chk("stall_hold_id", bus.out_id, 2);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_regrant", bus.req_ready, 4'b0100);
        cyc();
        chk("release_new_data", bus.out_data, 16'h00BB);
        bus.req_valid = '0;
        cyc();
        chk("drain_empty", bus.out_valid, 0);
        chk("drain_hold_data", bus.out_data, 16'h00BB);

        // Single word from requester 1, then nothing: one cycle of valid, pointer moves to 2.
        bus.req_valid = 4'b0010;
        bus.req_data[1*DW +: DW] = 16'hBEEF;
        cyc();
        chk("single_valid", bus.out_valid, 1);
        chk("single_data", bus.out_data, 16'hBEEF);
        bus.req_valid = '0;
        cyc();
        chk("single_gone", bus.out_valid, 0);
        cyc();
        bus.req_valid = '1;
        #1;
        chk("single_ptr_is_2", bus.req_ready, 4'b0100);
        cyc();
        bus.req_valid = '0;
        cyc();

        // Reset while full and stalled: word dropped at once, then the scan restarts at 0.
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: DW] = 16'h1234;
        bus.out_ready = 1'b0;
        cyc();
        chk("pre_rst_full", bus.out_data, 16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_data", bus.out_data, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
        model_reset();
        bus.req_valid = 4'b1010;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", bus.req_ready, 4'b0010);
        cyc();

        // Randomized traffic against the model and scoreboard.
        for (int c = 0; c < 10000; c++) begin
            bus.req_valid = NR'($urandom | $urandom);
            bus.req_data  = (NR*DW)'({$urandom, $urandom});
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", sb.size(), 0);

        // Two-requester, one-bit build: rotation then stall/release.
        sbus.req_valid = 2'b11;
        sbus.req_data  = 2'b10;
        sbus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("small_rot_id", sbus.out_id, c % 2);
            chk("small_rot_data", sbus.out_data, c % 2);
        end
        sbus.req_valid = 2'b10;
        sbus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("small_stall_valid", sbus.out_valid, 1);
        chk("small_stall_id", sbus.out_id, 1);
        for (int c = 0; c < 5; c++) begin
            chk("small_stall_no_grant", sbus.req_ready, 0);
            @(posedge clk);
            #1;
            chk("small_stall_hold", sbus.out_id, 1);
        end
        sbus.out_ready = 1'b1;
        #1;
        chk("small_release_grant", sbus.req_ready, 2'b10);
        @(posedge clk);
        #1;
        sbus.req_valid = '0;
        @(posedge clk);
        #1;
        chk("small_drained", sbus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/test_opt_reg_arb.md
TEST_OPT_REG_ARB -- requirements
Module: test_opt_reg_arb

Interface
REQ-001 The module SHALL have parameter DataWidth, default 16: width of each requester's data word and of the shared output register.
REQ-002 The module SHALL have parameter NumReq, default 4, legal range 2..8: number of requesters sharing the register.
REQ-003 The module SHALL derive IdWidth = max(1, ceil(log2(NumReq))) internally; it is not a port-level parameter.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: req_valid  input  NumReq  bit i = requester i offers a word.
REQ-007 Port: req_data  input  NumReq*DataWidth  requester i word in bits [i*DataWidth +: DataWidth].
REQ-008 Port: req_ready  output  NumReq  one-hot-or-zero grant; bit i = requester i's word is taken this cycle.
REQ-009 Port: out_valid  output  1  shared register holds a word.
REQ-010 Port: out_data  output  DataWidth  registered word.
REQ-011 Port: out_id  output  IdWidth  index of the requester that supplied out_data.
REQ-012 Port: out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-013 Two states SHALL exist, encoded by out_valid: EMPTY (0) and FULL (1).
REQ-014 Load enable SHALL be load = !out_valid || out_ready.
REQ-015 req_ready SHALL be combinational from req_valid, out_valid, out_ready and rr_ptr. The out_ready->req_ready path is permitted.
REQ-016 When load=1 and any req_valid bit is set, exactly one req_ready bit SHALL assert: the first set req_valid bit found scanning upward from index rr_ptr, wrapping NumReq-1 -> 0.
REQ-017 When load=0 or req_valid=0, req_ready SHALL be all zeros.
REQ-018 req_ready[i] SHALL never assert while req_valid[i]=0.
REQ-019 On a transfer from requester g, the next edge SHALL set out_valid=1, out_data=req_data word g, out_id=g.
REQ-020 Transfer latency SHALL be 1 cycle.
REQ-021 Sustained throughput SHALL be one word per cycle while out_ready=1.
REQ-022 On a transfer from requester g, rr_ptr SHALL update to (g+1) mod NumReq. Otherwise rr_ptr SHALL hold.
REQ-023 FULL with out_ready=1 and no transfer SHALL go to EMPTY. out_data/out_id hold their last values.
REQ-024 FULL with out_ready=1 and a transfer SHALL stay FULL with the new word (simultaneous drain and fill).
REQ-025 FULL with out_ready=0 SHALL hold out_valid, out_data and out_id stable. No grants are issued.
REQ-026 EMPTY SHALL ignore out_ready.
REQ-027 Fairness: a requester holding req_valid=1 SHALL be granted within NumReq consecutive transfers.
REQ-028 No word SHALL be lost or duplicated. Each req handshake maps to exactly one out handshake, in grant order.

Reset
REQ-029 While rst_n=0, asynchronously: out_valid=0, out_data=0, out_id=0, rr_ptr=0, req_ready=0.
REQ-030 A word held in the register when reset asserts SHALL be discarded.
REQ-031 The first grant after rst_n deasserts SHALL follow the scan from index 0.

Verification
REQ-032 Reset mid-FULL (out_valid=1, out_data=0x1234, out_ready=0), assert rst_n=0 -> out_valid=0, out_data=0, req_ready=0 before the next edge.
REQ-033 NumReq=4, all req_valid=1 after reset, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3; out_valid=1 from cycle 1; one req_ready bit per cycle.
REQ-034 Only req 2 valid with data 0x00AA, out_ready=0 -> req_ready=0100 in cycle 0. Then FULL holds 0x00AA/id 2 for 5 stalled cycles with req_ready=0. Releasing out_ready drains it and grants req 2 again the same cycle.
REQ-035 Single word from req 1 (0xBEEF), out_ready=1, no further requests -> out_valid 1 for exactly one cycle, then EMPTY; rr_ptr=2.
REQ-036 Random req_valid/req_data/out_ready for 10k cycles, scoreboard per requester -> no loss, duplication or reorder; every grant matches REQ-016; max wait <= NumReq transfers.
REQ-037 DataWidth=1, NumReq=2 build -> REQ-033 and REQ-034 pass with IdWidth=1.
